// File: rtl/em_stage_reg_if.sv
// E-stage inputs and M-stage outputs of the E/M pipeline register.
// slave is the register side, master is the producer/consumer side.
interface em_stage_reg_if;
    logic [31:0] E_PC;
    logic        E_BD;
    logic [31:0] E_Instr;
    logic [4:0]  E_ExcCode;
    logic [31:0] E_AO;
    logic [31:0] E_HILO;
    logic [1:0]  E_ResSel;
    logic [31:0] E_RTData;
    logic [4:0]  E_WA;
    logic        E_RegWrite;
    logic        E_MemRead;
    logic        E_MemWrite;
    logic        E_excOv;
    logic        E_excOvDM;

    logic [31:0] M_PC;
    logic [31:0] M_Instr;
    logic [31:0] M_Res;
    logic [31:0] M_RTData;
    logic        M_BD;
    logic        M_RegWrite;
    logic        M_MemRead;
    logic        M_MemWrite;
    logic [4:0]  M_WA;
    logic [4:0]  M_ExcCode;
    logic        M_Valid;
    logic        M_FwdEn;
    logic [31:0] M_FwdData;

    modport slave (
        input  E_PC, E_BD, E_Instr, E_ExcCode, E_AO, E_HILO, E_ResSel, E_RTData,
               E_WA, E_RegWrite, E_MemRead, E_MemWrite, E_excOv, E_excOvDM,
        output M_PC, M_Instr, M_Res, M_RTData, M_BD, M_RegWrite, M_MemRead,
               M_MemWrite, M_WA, M_ExcCode, M_Valid, M_FwdEn, M_FwdData
    );

    modport master (
        output E_PC, E_BD, E_Instr, E_ExcCode, E_AO, E_HILO, E_ResSel, E_RTData,
               E_WA, E_RegWrite, E_MemRead, E_MemWrite, E_excOv, E_excOvDM,
        input  M_PC, M_Instr, M_Res, M_RTData, M_BD, M_RegWrite, M_MemRead,
               M_MemWrite, M_WA, M_ExcCode, M_Valid, M_FwdEn, M_FwdData
    );
endinterface

// File: rtl/em_stage_reg.sv
// E/M pipeline register: one-cycle capture with cause merge; en=0 holds, while req/flush
// override the stall (req loads the handler PC, flush inserts a bubble keeping PC/BD).
module em_stage_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           en,
    input  logic           flush,
    input  logic           req,
    em_stage_reg_if.slave  bus
);
    logic [4:0]  exc_merged;
    logic [31:0] res_sel;
    logic        suppress;

    // Upstream cause outranks anything detected in this stage.
    always_comb begin
        exc_merged = 5'd0;
        if (bus.E_ExcCode != 5'd0)
            exc_merged = bus.E_ExcCode;
        else if (bus.E_excOv)
            exc_merged = 5'd12;
        else if (bus.E_excOvDM && bus.E_MemRead)
            exc_merged = 5'd4;
        else if (bus.E_excOvDM && bus.E_MemWrite)
            exc_merged = 5'd5;
    end

    always_comb begin
        res_sel = 32'd0;
        case (bus.E_ResSel)
            2'd0:    res_sel = bus.E_AO;
            2'd1:    res_sel = bus.E_HILO;
            2'd2:    res_sel = bus.E_PC + 32'd8;
            default: res_sel = 32'd0;
        endcase
    end

    assign suppress = (exc_merged != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.M_PC       <= RESET_PC;
            bus.M_BD       <= 1'b0;
            bus.M_Instr    <= 32'd0;
            bus.M_Res      <= 32'd0;
            bus.M_RTData   <= 32'd0;
            bus.M_WA       <= 5'd0;
            bus.M_ExcCode  <= 5'd0;
            bus.M_RegWrite <= 1'b0;
            bus.M_MemRead  <= 1'b0;
            bus.M_MemWrite <= 1'b0;
            bus.M_Valid    <= 1'b0;
        end else if (req || flush) begin
            bus.M_PC       <= req ? HANDLER_PC : bus.E_PC;
            bus.M_BD       <= req ? 1'b0 : bus.E_BD;
            bus.M_Instr    <= 32'd0;
            bus.M_Res      <= 32'd0;
            bus.M_RTData   <= 32'd0;
            bus.M_WA       <= 5'd0;
            bus.M_ExcCode  <= 5'd0;
            bus.M_RegWrite <= 1'b0;
            bus.M_MemRead  <= 1'b0;
            bus.M_MemWrite <= 1'b0;
            bus.M_Valid    <= 1'b0;
        end else if (en) begin
            bus.M_PC       <= bus.E_PC;
            bus.M_BD       <= bus.E_BD;
            bus.M_Instr    <= bus.E_Instr;
            bus.M_Res      <= res_sel;
            bus.M_RTData   <= bus.E_RTData;
            bus.M_WA       <= bus.E_WA;
            bus.M_ExcCode  <= exc_merged;
            // An excepting instruction still carries PC/BD for EPC but must not write state.
            bus.M_RegWrite <= bus.E_RegWrite & ~suppress;
            bus.M_MemRead  <= bus.E_MemRead  & ~suppress;
            bus.M_MemWrite <= bus.E_MemWrite & ~suppress;
            bus.M_Valid    <= 1'b1;
        end
    end

    assign bus.M_FwdEn   = bus.M_Valid & bus.M_RegWrite & (bus.M_WA != 5'd0);
    assign bus.M_FwdData = bus.M_Res;
endmodule
